// File: rtl/hls_run_seq_pkg.sv
// Shared types for the HLS run sequencer: FSM states, record status codes and
// the record width helper.
package hls_run_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RST,
    START,
    WAIT,
    RECORD,
    NEXT,
    DONE
  } state_t;

  localparam logic [1:0] STATUS_FAIL    = 2'b00;
  localparam logic [1:0] STATUS_PASS    = 2'b01;
  localparam logic [1:0] STATUS_TIMEOUT = 2'b10;

  function automatic int rec_width(input int run_w, input int cnt_w);
    return 2 + run_w + cnt_w;
  endfunction

endpackage

// File: rtl/hls_run_seq_result_fifo.sv
// First-word-fall-through result FIFO; a push while full is accepted only
// together with a pop in the same cycle.
module hls_run_seq_result_fifo #(
  parameter int WIDTH = 50,
  parameter int DEPTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  input  logic             pop,
  output logic             empty,
  output logic [WIDTH-1:0] pop_data
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  // Extra pointer bit separates full from empty when the indices coincide.
  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr_reg[AW-1:0]] <= push_data;
  end

  assign pop_data = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/hls_run_sequencer.sv
// Runs an HLS accelerator cfg_num_runs times, timing each run and queueing one
// result record per run. Define HLS_RUN_SEQUENCER_STATS_EN for min/max latency outputs.
module hls_run_sequencer
  import hls_run_seq_pkg::*;
#(
  parameter int CNT_W      = 32,
  parameter int RUN_W      = 16,
  parameter int TIMEOUT    = 200000000,
  parameter int RST_CYCLES = 2,
  parameter int RES_DEPTH  = 8
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 go,
  input  logic [RUN_W-1:0]                     cfg_num_runs,
  output logic                                 dut_reset,
  output logic                                 dut_start_port,
  input  logic                                 dut_done_port,
  input  logic                                 dut_success,
  output logic                                 res_valid,
  input  logic                                 res_ready,
  output logic [rec_width(RUN_W, CNT_W)-1:0]   res_data,
  output logic                                 busy,
  output logic                                 all_done,
  output logic [RUN_W-1:0]                     fail_count
`ifdef HLS_RUN_SEQUENCER_STATS_EN
  ,
  output logic [CNT_W-1:0]                     stat_min_cycles,
  output logic [CNT_W-1:0]                     stat_max_cycles
`endif
);

  localparam int              REC_W     = rec_width(RUN_W, CNT_W);
  localparam int              RC_W      = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RC_W-1:0] RC_LAST   = RC_W'(RST_CYCLES - 1);
  localparam logic [CNT_W:0]  TIMEOUT_X = (CNT_W + 1)'(TIMEOUT);

  state_t            state_reg, state_next;
  logic [RC_W-1:0]   rst_cnt_reg, rst_cnt_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [RUN_W-1:0]  run_idx_reg, run_idx_next;
  logic [RUN_W-1:0]  num_runs_reg, num_runs_next;
  logic [RUN_W-1:0]  fail_count_reg, fail_count_next;
  logic [1:0]        rec_status_reg, rec_status_next;
  logic [CNT_W-1:0]  rec_cycles_reg, rec_cycles_next;

  logic              go_accept;
  logic              push;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W:0]    cnt_plus;
  logic [CNT_W-1:0]  cnt_sat;
  logic [RUN_W-1:0]  run_idx_inc;
  logic [1:0]        done_status;

  assign go_accept   = go && ((state_reg == IDLE) || (state_reg == DONE));
  assign push        = (state_reg == RECORD) && (!fifo_full || res_ready);
  assign cnt_plus    = {1'b0, cnt_reg} + 1'b1;
  assign cnt_sat     = cnt_plus[CNT_W] ? '1 : cnt_plus[CNT_W-1:0];
  assign run_idx_inc = run_idx_reg + 1'b1;
  assign done_status = dut_success ? STATUS_PASS : STATUS_FAIL;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      rst_cnt_reg    <= '0;
      cnt_reg        <= '0;
      run_idx_reg    <= '0;
      num_runs_reg   <= '0;
      fail_count_reg <= '0;
      rec_status_reg <= STATUS_FAIL;
      rec_cycles_reg <= '0;
    end else begin
      state_reg      <= state_next;
      rst_cnt_reg    <= rst_cnt_next;
      cnt_reg        <= cnt_next;
      run_idx_reg    <= run_idx_next;
      num_runs_reg   <= num_runs_next;
      fail_count_reg <= fail_count_next;
      rec_status_reg <= rec_status_next;
      rec_cycles_reg <= rec_cycles_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    rst_cnt_next    = rst_cnt_reg;
    cnt_next        = cnt_reg;
    run_idx_next    = run_idx_reg;
    num_runs_next   = num_runs_reg;
    fail_count_next = fail_count_reg;
    rec_status_next = rec_status_reg;
    rec_cycles_next = rec_cycles_reg;
    case (state_reg)
      IDLE, DONE: begin
        if (go_accept) begin
          num_runs_next   = cfg_num_runs;
          run_idx_next    = '0;
          fail_count_next = '0;
          rst_cnt_next    = '0;
          state_next      = (cfg_num_runs == '0) ? DONE : RST;
        end
      end
      RST: begin
        if (rst_cnt_reg == RC_LAST) begin
          rst_cnt_next = '0;
          state_next   = START;
        end else begin
          rst_cnt_next = rst_cnt_reg + 1'b1;
        end
      end
      START: begin
        cnt_next = CNT_W'(1);
        if (dut_done_port) begin
          rec_status_next = done_status;
          rec_cycles_next = CNT_W'(1);
          state_next      = RECORD;
        end else begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        cnt_next = cnt_sat;
        // Done takes priority over a timeout landing on the same cycle.
        if (dut_done_port) begin
          rec_status_next = done_status;
          rec_cycles_next = cnt_sat;
          state_next      = RECORD;
        end else if (cnt_plus > TIMEOUT_X) begin
          rec_status_next = STATUS_TIMEOUT;
          rec_cycles_next = CNT_W'(TIMEOUT);
          state_next      = RECORD;
        end
      end
      RECORD: begin
        if (push) begin
          if ((rec_status_reg != STATUS_PASS) && (fail_count_reg != '1))
            fail_count_next = fail_count_reg + 1'b1;
          state_next = (rec_status_reg == STATUS_TIMEOUT) ? DONE : NEXT;
        end
      end
      NEXT: begin
        run_idx_next = run_idx_inc;
        state_next   = (run_idx_inc == num_runs_reg) ? DONE : RST;
      end
      default: state_next = IDLE;
    endcase
  end

  // Decoded straight from state so an asynchronous reset drops dut_reset at once.
  always_comb begin
    dut_reset      = 1'b0;
    dut_start_port = 1'b0;
    busy           = 1'b0;
    all_done       = 1'b0;
    case (state_reg)
      RST:                 busy = 1'b1;
      START:               begin dut_reset = 1'b1; dut_start_port = 1'b1; busy = 1'b1; end
      WAIT, RECORD, NEXT:  begin dut_reset = 1'b1; busy = 1'b1; end
      DONE:                all_done = 1'b1;
      default:             ;
    endcase
  end

  assign fail_count = fail_count_reg;
  assign res_valid  = !fifo_empty;

  hls_run_seq_result_fifo #(
    .WIDTH (REC_W),
    .DEPTH (RES_DEPTH)
  ) u_result_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data ({rec_status_reg, run_idx_reg, rec_cycles_reg}),
    .full      (fifo_full),
    .pop       (res_ready),
    .empty     (fifo_empty),
    .pop_data  (res_data)
  );

`ifdef HLS_RUN_SEQUENCER_STATS_EN
  logic [CNT_W-1:0] stat_min_reg;
  logic [CNT_W-1:0] stat_max_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stat_min_reg <= '0;
      stat_max_reg <= '0;
    end else if (go_accept) begin
      stat_min_reg <= '1;
      stat_max_reg <= '0;
    end else if (push && (rec_status_reg != STATUS_TIMEOUT)) begin
      if (rec_cycles_reg < stat_min_reg) stat_min_reg <= rec_cycles_reg;
      if (rec_cycles_reg > stat_max_reg) stat_max_reg <= rec_cycles_reg;
    end
  end

  assign stat_min_cycles = stat_min_reg;
  assign stat_max_cycles = stat_max_reg;
`endif

endmodule

// File: tb/tb_hls_run_sequencer.sv
// Scoreboard bench for hls_run_sequencer with a behavioural accelerator model
// whose per-run latency and success come from directed tables.
module tb_hls_run_sequencer;

  localparam int CNT_W      = 32;
  localparam int RUN_W      = 16;
  localparam int TIMEOUT    = 20;
  localparam int RST_CYCLES = 2;
  localparam int RES_DEPTH  = 2;
  localparam int REC_W      = 2 + RUN_W + CNT_W;

  localparam logic [1:0] ST_FAIL = 2'b00;
  localparam logic [1:0] ST_PASS = 2'b01;
  localparam logic [1:0] ST_TO   = 2'b10;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             go = 1'b0;
  logic [RUN_W-1:0] cfg_num_runs = '0;
  logic             res_ready = 1'b0;
  logic             dut_reset;
  logic             dut_start_port;
  logic             dut_done_port;
  logic             dut_success;
  logic             res_valid;
  logic [REC_W-1:0] res_data;
  logic             busy;
  logic             all_done;
  logic [RUN_W-1:0] fail_count;
`ifdef HLS_RUN_SEQUENCER_STATS_EN
  logic [CNT_W-1:0] stat_min_cycles;
  logic [CNT_W-1:0] stat_max_cycles;
`endif

  hls_run_sequencer #(
    .CNT_W      (CNT_W),
    .RUN_W      (RUN_W),
    .TIMEOUT    (TIMEOUT),
    .RST_CYCLES (RST_CYCLES),
    .RES_DEPTH  (RES_DEPTH)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .go             (go),
    .cfg_num_runs   (cfg_num_runs),
    .dut_reset      (dut_reset),
    .dut_start_port (dut_start_port),
    .dut_done_port  (dut_done_port),
    .dut_success    (dut_success),
    .res_valid      (res_valid),
    .res_ready      (res_ready),
    .res_data       (res_data),
    .busy           (busy),
    .all_done       (all_done),
    .fail_count     (fail_count)
`ifdef HLS_RUN_SEQUENCER_STATS_EN
    ,
    .stat_min_cycles (stat_min_cycles),
    .stat_max_cycles (stat_max_cycles)
`endif
  );

  always #5 clock = ~clock;

  int               n_cmp = 0;
  int               n_err = 0;
  int               pop_cnt = 0;
  logic [REC_W-1:0] exp_q[$];

  // Accelerator model: raises done on cycle lat_tbl[run] counted from start (1 = start cycle).
  int lat_tbl [16];
  bit succ_tbl [16];
  int start_cnt = 0;
  int cur_run = 0;
  int tb_cyc = 0;
  bit tb_active = 1'b0;
  int lat_now;
  bit succ_now;

  always @(posedge clock) begin
    if (!reset) begin
      tb_active <= 1'b0;
    end else if (go && !busy) begin
      start_cnt <= 0;
      tb_active <= 1'b0;
    end else if (dut_start_port) begin
      cur_run   <= start_cnt;
      start_cnt <= start_cnt + 1;
      tb_active <= !dut_done_port;
      tb_cyc    <= 2;
    end else if (tb_active) begin
      if (dut_done_port) tb_active <= 1'b0;
      tb_cyc <= tb_cyc + 1;
    end
  end

  always_comb begin
    lat_now       = dut_start_port ? lat_tbl[start_cnt[3:0]] : lat_tbl[cur_run[3:0]];
    succ_now      = dut_start_port ? succ_tbl[start_cnt[3:0]] : succ_tbl[cur_run[3:0]];
    dut_done_port = (dut_start_port && (lat_now == 1)) ||
                    (!dut_start_port && tb_active && (lat_now != 0) && (tb_cyc == lat_now));
    dut_success   = dut_done_port && succ_now;
  end

  function automatic logic [REC_W-1:0] mk(input logic [1:0] st, input int idx, input int cyc);
    return {st, idx[RUN_W-1:0], cyc[CNT_W-1:0]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, act, expv);
    end
  endtask

  task automatic set_run(input int i, input int lat, input bit s);
    lat_tbl[i]  = lat;
    succ_tbl[i] = s;
  endtask

  task automatic start_campaign(input int n);
    @(posedge clock); #1;
    cfg_num_runs = RUN_W'(n);
    go = 1'b1;
    @(posedge clock); #1;
    go = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int k = 0;
    while (!all_done && k < 2000) begin
      @(posedge clock); #1;
      k++;
    end
    chk(name, 64'(all_done), 64'(1));
  endtask

  task automatic drain(input string name);
    int k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      @(posedge clock); #1;
      k++;
    end
    chk(name, 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    fork
      forever begin
        @(negedge clock);
        if (reset && res_valid && res_ready) begin
          pop_cnt++;
          if (exp_q.size() == 0) chk("record_expected", 64'(exp_q.size()), 64'(1));
          else begin
            chk("record", 64'(res_data), 64'(exp_q.pop_front()));
            $display("record %0d: status=%0b run=%0d cycles=%0d", pop_cnt,
                     res_data[REC_W-1 -: 2], res_data[CNT_W +: RUN_W], res_data[CNT_W-1:0]);
          end
        end
      end
    join_none

    for (int i = 0; i < 16; i++) set_run(i, 0, 1'b0);

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    chk("rst_dut_reset", 64'(dut_reset), 64'(0));
    chk("rst_start", 64'(dut_start_port), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_all_done", 64'(all_done), 64'(0));
    chk("rst_fail_count", 64'(fail_count), 64'(0));
    chk("rst_res_valid", 64'(res_valid), 64'(0));
    chk("rst_res_data", 64'(res_data), 64'(0));
`ifdef HLS_RUN_SEQUENCER_STATS_EN
    chk("rst_stat_min", 64'(stat_min_cycles), 64'(0));
    chk("rst_stat_max", 64'(stat_max_cycles), 64'(0));
`endif
    reset = 1'b1;
    res_ready = 1'b1;

    // Three passing runs of latency 5; a go mid-campaign must be ignored
    for (int i = 0; i < 3; i++) begin
      set_run(i, 5, 1'b1);
      exp_q.push_back(mk(ST_PASS, i, 5));
    end
    start_campaign(3);
    repeat (3) @(posedge clock);
    #1;
    cfg_num_runs = RUN_W'(7);
    go = 1'b1;
    @(posedge clock); #1;
    go = 1'b0;
    wait_done("t1_all_done");
    drain("t1_drain");
    chk("t1_fail_count", 64'(fail_count), 64'(0));
    chk("t1_busy", 64'(busy), 64'(0));
    chk("t1_done_dut_reset", 64'(dut_reset), 64'(0));
    chk("t1_starts", 64'(start_cnt), 64'(3));

    // Done asserted in the start cycle
    set_run(0, 1, 1'b1);
    exp_q.push_back(mk(ST_PASS, 0, 1));
    start_campaign(1);
    wait_done("t2_all_done");
    drain("t2_drain");

    // Timeout aborts the campaign after run 0
    for (int i = 0; i < 4; i++) set_run(i, 0, 1'b1);
    exp_q.push_back(mk(ST_TO, 0, TIMEOUT));
    start_campaign(4);
    wait_done("t3_all_done");
    drain("t3_drain");
    chk("t3_fail_count", 64'(fail_count), 64'(1));
    chk("t3_starts", 64'(start_cnt), 64'(1));
`ifdef HLS_RUN_SEQUENCER_STATS_EN
    chk("t3_stat_min", 64'(stat_min_cycles), 64'hFFFF_FFFF);
    chk("t3_stat_max", 64'(stat_max_cycles), 64'(0));
`endif

    // Zero runs: straight to DONE, no records, fail_count cleared
    start_campaign(0);
    chk("t0_all_done", 64'(all_done), 64'(1));
    chk("t0_fail_count", 64'(fail_count), 64'(0));
    repeat (5) @(posedge clock);
    #1;
    chk("t0_no_record", 64'(res_valid), 64'(0));

    // Back-pressure: FIFO of 2 fills, FSM stalls, then drains five in order
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_run(i, 3, 1'b1);
      exp_q.push_back(mk(ST_PASS, i, 3));
    end
    start_campaign(5);
    repeat (60) @(posedge clock);
    #1;
    chk("t4_stall_busy", 64'(busy), 64'(1));
    chk("t4_stall_starts", 64'(start_cnt), 64'(3));
    chk("t4_stall_valid", 64'(res_valid), 64'(1));
    chk("t4_no_pops", 64'(exp_q.size()), 64'(5));
    res_ready = 1'b1;
    wait_done("t4_all_done");
    drain("t4_drain");

    // Middle run fails
    set_run(0, 4, 1'b1); exp_q.push_back(mk(ST_PASS, 0, 4));
    set_run(1, 4, 1'b0); exp_q.push_back(mk(ST_FAIL, 1, 4));
    set_run(2, 4, 1'b1); exp_q.push_back(mk(ST_PASS, 2, 4));
    start_campaign(3);
    wait_done("t5_all_done");
    drain("t5_drain");
    chk("t5_fail_count", 64'(fail_count), 64'(1));

    // Latency statistics 7, 3, 9
    set_run(0, 7, 1'b1); exp_q.push_back(mk(ST_PASS, 0, 7));
    set_run(1, 3, 1'b1); exp_q.push_back(mk(ST_PASS, 1, 3));
    set_run(2, 9, 1'b0); exp_q.push_back(mk(ST_FAIL, 2, 9));
    start_campaign(3);
    wait_done("t6_all_done");
    drain("t6_drain");
`ifdef HLS_RUN_SEQUENCER_STATS_EN
    chk("t6_stat_min", 64'(stat_min_cycles), 64'(3));
    chk("t6_stat_max", 64'(stat_max_cycles), 64'(9));
`endif

    // Reset in run 2 WAIT with records still queued
    res_ready = 1'b0;
    set_run(0, 4, 1'b0);
    set_run(1, 4, 1'b1);
    set_run(2, 0, 1'b1);
    start_campaign(3);
    begin
      int k = 0;
      while (start_cnt < 3 && k < 200) begin
        @(posedge clock); #1;
        k++;
      end
    end
    chk("t7_reached_run2", 64'(start_cnt), 64'(3));
    repeat (3) @(posedge clock);
    #1;
    chk("t7_pre_dut_reset", 64'(dut_reset), 64'(1));
    chk("t7_pre_valid", 64'(res_valid), 64'(1));
    #2;
    reset = 1'b0;
    #1;
    chk("t7_async_dut_reset", 64'(dut_reset), 64'(0));
    chk("t7_fifo_empty", 64'(res_valid), 64'(0));
    chk("t7_busy", 64'(busy), 64'(0));
    chk("t7_fail_count", 64'(fail_count), 64'(0));
    exp_q.delete();
    @(posedge clock); #1;
    reset = 1'b1;
    res_ready = 1'b1;

    // Recovery after reset
    set_run(0, 2, 1'b1);
    exp_q.push_back(mk(ST_PASS, 0, 2));
    start_campaign(1);
    wait_done("t8_all_done");
    drain("t8_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
